// File: rtl/rx_token_checker.sv
// rx_token_checker
//   Receive-side PID/token checker sitting between the byte deserializer and
//   link_control. It validates the PID complement nibble, the token CRC5 and
//   the packet length for each PID class. It filters tokens by device address
//   and gates handshakes with the receive window. It then reports accepted
//   PIDs (and token fields) or a single error pulse, one cycle after rx_eop.
//   DATA packets are skipped without any pulse; the CRC16 receiver owns them.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   ms                1 = master, 0 = slave (address filter is slave-only)
//   self_addr[6:0]    device address used by the token filter
//   rx_handshake_on   handshake receive window, sampled with the PID byte
//   rx_sop            start-of-packet pulse, coincident with the PID byte strobe
//   rx_byte_valid     byte strobe
//   rx_byte[7:0]      received byte, bit order already restored
//   rx_eop            end-of-packet pulse, after the last byte strobe
//   rx_pid_en         pulse: token or handshake accepted
//   rx_pid[3:0]       last accepted PID (held)
//   rx_addr[6:0]      last accepted token address (held)
//   rx_endp[3:0]      last accepted token endpoint (held)
//   rx_frame[10:0]    last accepted SOF frame number (held)
//   rx_pid_err        pulse: PID complement mismatch or reserved PID
//   rx_crc_err        pulse: CRC5 residual mismatch
//   rx_len_err        pulse: wrong byte count for the PID class
//   rx_busy           high from the cycle after rx_sop through the rx_eop cycle
module rx_token_checker #(
    parameter bit ADDR_FILTER_EN = 1'b1,
    parameter bit HS_GATE_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ms,
    input  logic [6:0]  self_addr,
    input  logic        rx_handshake_on,
    input  logic        rx_sop,
    input  logic        rx_byte_valid,
    input  logic [7:0]  rx_byte,
    input  logic        rx_eop,
    output logic        rx_pid_en,
    output logic [3:0]  rx_pid,
    output logic [6:0]  rx_addr,
    output logic [3:0]  rx_endp,
    output logic [10:0] rx_frame,
    output logic        rx_pid_err,
    output logic        rx_crc_err,
    output logic        rx_len_err,
    output logic        rx_busy
);

    typedef enum logic [2:0] {IDLE, TOK1, TOK2, TAIL, HS, SKIP} state_t;

    localparam logic [3:0] PID_SOF       = 4'b0101;
    localparam logic [4:0] CRC5_INIT     = 5'b11111;
    localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;

    // One byte of CRC5 (x^5 + x^2 + 1), bits taken LSB first.
    function automatic logic [4:0] crc5_byte(input logic [4:0] crc_in, input logic [7:0] data);
        logic [4:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            fb = data[i] ^ c[4];
            c  = {c[3:0], 1'b0};
            if (fb) c = c ^ 5'b00101;
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  crc_q, crc_d;
    logic [3:0]  pid_q, pid_d;
    logic        pid_err_q, pid_err_d;
    logic        len_err_q, len_err_d;
    logic        hs_on_q, hs_on_d;
    logic [7:0]  byte1_q, byte1_d;
    logic [7:0]  byte2_q, byte2_d;

    logic        rx_pid_en_q, rx_pid_en_d;
    logic [3:0]  rx_pid_q, rx_pid_d;
    logic [6:0]  rx_addr_q, rx_addr_d;
    logic [3:0]  rx_endp_q, rx_endp_d;
    logic [10:0] rx_frame_q, rx_frame_d;
    logic        rx_pid_err_q, rx_pid_err_d;
    logic        rx_crc_err_q, rx_crc_err_d;
    logic        rx_len_err_q, rx_len_err_d;

    logic        addr_drop;
    logic        hs_drop;

    assign addr_drop = ADDR_FILTER_EN && !ms && (pid_q != PID_SOF) && (byte1_q[6:0] != self_addr);
    assign hs_drop   = HS_GATE_EN && !hs_on_q;

    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        pid_d        = pid_q;
        pid_err_d    = pid_err_q;
        len_err_d    = len_err_q;
        hs_on_d      = hs_on_q;
        byte1_d      = byte1_q;
        byte2_d      = byte2_q;
        rx_pid_en_d  = 1'b0;
        rx_pid_err_d = 1'b0;
        rx_crc_err_d = 1'b0;
        rx_len_err_d = 1'b0;
        rx_pid_d     = rx_pid_q;
        rx_addr_d    = rx_addr_q;
        rx_endp_d    = rx_endp_q;
        rx_frame_d   = rx_frame_q;

        if (rx_sop && rx_byte_valid) begin
            // A new PID byte always restarts decoding, dropping any packet in flight.
            pid_d     = rx_byte[3:0];
            hs_on_d   = rx_handshake_on;
            crc_d     = CRC5_INIT;
            pid_err_d = 1'b0;
            len_err_d = 1'b0;
            if ((rx_byte[3:0] != ~rx_byte[7:4]) || (rx_byte[1:0] == 2'b00)) begin
                state_d   = SKIP;
                pid_err_d = 1'b1;
            end else begin
                case (rx_byte[1:0])
                    2'b01:   state_d = TOK1;
                    2'b10:   state_d = HS;
                    default: state_d = SKIP;
                endcase
            end
        end else if (rx_eop) begin
            state_d = IDLE;
            // Resolution: pid_err > len_err > crc_err, then filtering, then accept.
            if (state_q != IDLE) begin
                if (pid_err_q) begin
                    rx_pid_err_d = 1'b1;
                end else if (len_err_q || (state_q == TOK1) || (state_q == TOK2)) begin
                    rx_len_err_d = 1'b1;
                end else if (state_q == TAIL) begin
                    if (crc_q != CRC5_RESIDUAL) begin
                        rx_crc_err_d = 1'b1;
                    end else if (pid_q == PID_SOF) begin
                        rx_pid_en_d = 1'b1;
                        rx_pid_d    = pid_q;
                        rx_frame_d  = {byte2_q[2:0], byte1_q};
                    end else if (!addr_drop) begin
                        rx_pid_en_d = 1'b1;
                        rx_pid_d    = pid_q;
                        rx_addr_d   = byte1_q[6:0];
                        rx_endp_d   = {byte2_q[2:0], byte1_q[7]};
                    end
                end else if (state_q == HS) begin
                    if (!hs_drop) begin
                        rx_pid_en_d = 1'b1;
                        rx_pid_d    = pid_q;
                    end
                end
            end
        end else if (rx_byte_valid) begin
            case (state_q)
                TOK1: begin
                    byte1_d = rx_byte;
                    crc_d   = crc5_byte(crc_q, rx_byte);
                    state_d = TOK2;
                end
                TOK2: begin
                    byte2_d = rx_byte;
                    crc_d   = crc5_byte(crc_q, rx_byte);
                    state_d = TAIL;
                end
                TAIL, HS: len_err_d = 1'b1;
                default: ;
            endcase
        end
    end

    // ---- control and output register stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            crc_q        <= CRC5_INIT;
            pid_q        <= '0;
            pid_err_q    <= 1'b0;
            len_err_q    <= 1'b0;
            hs_on_q      <= 1'b0;
            rx_pid_en_q  <= 1'b0;
            rx_pid_q     <= '0;
            rx_addr_q    <= '0;
            rx_endp_q    <= '0;
            rx_frame_q   <= '0;
            rx_pid_err_q <= 1'b0;
            rx_crc_err_q <= 1'b0;
            rx_len_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            pid_q        <= pid_d;
            pid_err_q    <= pid_err_d;
            len_err_q    <= len_err_d;
            hs_on_q      <= hs_on_d;
            rx_pid_en_q  <= rx_pid_en_d;
            rx_pid_q     <= rx_pid_d;
            rx_addr_q    <= rx_addr_d;
            rx_endp_q    <= rx_endp_d;
            rx_frame_q   <= rx_frame_d;
            rx_pid_err_q <= rx_pid_err_d;
            rx_crc_err_q <= rx_crc_err_d;
            rx_len_err_q <= rx_len_err_d;
        end
    end

    // ---- token byte capture (data only, no reset needed) ----
    always_ff @(posedge clk) begin
        byte1_q <= byte1_d;
        byte2_q <= byte2_d;
    end

    assign rx_pid_en  = rx_pid_en_q;
    assign rx_pid     = rx_pid_q;
    assign rx_addr    = rx_addr_q;
    assign rx_endp    = rx_endp_q;
    assign rx_frame   = rx_frame_q;
    assign rx_pid_err = rx_pid_err_q;
    assign rx_crc_err = rx_crc_err_q;
    assign rx_len_err = rx_len_err_q;
    assign rx_busy    = (state_q != IDLE);

endmodule
